// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch unit.
package pc_fetch_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/pc_fetch.sv
// Architectural PC plus fetch/issue handshake: fetch a word, buffer it, hand it to
// the cores, then load the jump-select stage's next_pc.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] next_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                stall,
    input  logic                halt,
    output logic                halted,
    output logic                misaligned,
    output logic [31:0]         issue_count
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                misaligned_q, misaligned_d;
    logic [31:0]         count_q, count_d;

    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        count_d      = count_q;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;

        // stall masks req/valid, which in turn suppresses every state update below
        unique case (state_q)
            FETCH: begin
                imem_req = ~stall & ~reset;
                if (imem_req && imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = ~stall;
                if (instr_valid && instr_ready) begin
                    pc_d    = {next_pc[PC_WIDTH-1:2], 2'b00};
                    count_d = count_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end
                    state_d = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign halted      = (state_q == HALTED);
    assign misaligned  = misaligned_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed sequences plus an instruction scoreboard
// filled on each fetch handshake and drained on each handoff to the cores.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic [31:0] pc, pc_plus4, imem_addr, imem_rdata, instr, issue_count;
    logic        imem_req, imem_ready, instr_valid, instr_ready;
    logic        stall, halt, halted, misaligned;

    logic        ovr_en;
    logic [31:0] ovr_val;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .halt        (halt),
        .halted      (halted),
        .misaligned  (misaligned),
        .issue_count (issue_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, ~addr[15:0]};
    endfunction

    always_comb imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push the returned word on each fetch handshake, pop on handoff.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (imem_req && imem_ready) sb_q.push_back(imem_rdata);
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got handoff of %h expected none", instr);
                end else begin
                    check("sb_instr", instr, sb_q.pop_front());
                end
            end
        end
    end

    // Starting in FETCH just after an edge: one fetch cycle, one handoff cycle.
    task automatic fetch_issue(input logic [31:0] nxt, input logic hlt);
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        halt        = 1'b0;
        @(negedge clk);
        check("fi_req", 32'(imem_req), 32'd1);
        check("fi_addr", imem_addr, exp_pc);
        check("fi_valid_lo", 32'(instr_valid), 32'd0);
        cyc();
        next_pc = nxt;
        halt    = hlt;
        @(negedge clk);
        check("fi_valid_hi", 32'(instr_valid), 32'd1);
        check("fi_req_lo", 32'(imem_req), 32'd0);
        check("fi_pc_hold", pc, exp_pc);
        cyc();
        halt    = 1'b0;
        exp_pc  = {nxt[31:2], 2'b00};
        exp_cnt = exp_cnt + 32'd1;
        check("fi_pc", pc, exp_pc);
        check("fi_pc4", pc_plus4, exp_pc + 32'd4);
        check("fi_cnt", issue_count, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; next_pc = '0; imem_ready = 1'b1; instr_ready = 1'b1;
        stall = 1'b0; halt = 1'b0; ovr_en = 1'b0; ovr_val = '0;
        exp_pc = RST_PC; exp_cnt = '0;

        cyc();
        cyc();
        check("rst_pc", pc, RST_PC);
        check("rst_pc4", pc_plus4, RST_PC + 32'd4);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_cnt", issue_count, 32'd0);
        reset = 1'b0;

        // Sequential stream: 0x100, 0x104, 0x108
        for (int i = 0; i < 3; i++) fetch_issue(exp_pc + 32'd4, 1'b0);
        check("stream_cnt", issue_count, 32'd3);

        // Back-pressure with a fixed word in the buffer
        ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF; instr_ready = 1'b0;
        cyc();
        ovr_en = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_pc = $urandom;
            halt    = 1'b1;
            @(negedge clk);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", instr, 32'hDEAD_BEEF);
            check("bp_pc", pc, exp_pc);
            cyc();
        end
        halt = 1'b0; next_pc = 32'h40; instr_ready = 1'b1;
        cyc();
        exp_pc = 32'h40; exp_cnt = exp_cnt + 32'd1;
        check("bp_new_pc", pc, 32'h40);
        check("bp_new_pc4", pc_plus4, 32'h44);
        check("bp_cnt", issue_count, exp_cnt);

        // Stall in FETCH with memory ready
        stall = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stf_req", 32'(imem_req), 32'd0);
            check("stf_valid", 32'(instr_valid), 32'd0);
            cyc();
        end
        stall = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        check("stf_req_rel", 32'(imem_req), 32'd1);
        check("stf_nocap", 32'(instr_valid), 32'd0);
        cyc();
        imem_ready = 1'b1;
        @(negedge clk);
        check("stf_cap_req", 32'(imem_req), 32'd1);
        cyc();
        // Stall in ISSUE with cores ready
        stall = 1'b1; instr_ready = 1'b1; next_pc = 32'h200;
        @(negedge clk);
        check("sti_valid", 32'(instr_valid), 32'd0);
        cyc();
        check("sti_pc", pc, exp_pc);
        check("sti_cnt", issue_count, exp_cnt);
        stall = 1'b0;
        @(negedge clk);
        check("sti_valid_rel", 32'(instr_valid), 32'd1);
        cyc();
        exp_pc = 32'h200; exp_cnt = exp_cnt + 32'd1;
        check("sti_new_pc", pc, exp_pc);

        // Misaligned target, then sticky, then PC wrap
        check("mis_before", 32'(misaligned), 32'd0);
        fetch_issue(32'h0000_0036, 1'b0);
        check("mis_pc", pc, 32'h34);
        check("mis_set", 32'(misaligned), 32'd1);
        fetch_issue(32'hFFFF_FFFC, 1'b0);
        check("mis_sticky", 32'(misaligned), 32'd1);
        check("wrap_pc4", pc_plus4, 32'd0);

        // Halt on handoff, then nothing moves
        fetch_issue(32'h500, 1'b1);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1; instr_ready = 1'b1; next_pc = $urandom;
            @(negedge clk);
            check("hlt_halted", 32'(halted), 32'd1);
            check("hlt_req", 32'(imem_req), 32'd0);
            check("hlt_valid", 32'(instr_valid), 32'd0);
            check("hlt_pc", pc, 32'h500);
            check("hlt_cnt", issue_count, exp_cnt);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_pc = RST_PC; exp_cnt = '0;
        check("hrst_pc", pc, RST_PC);
        check("hrst_halted", 32'(halted), 32'd0);
        check("hrst_mis", 32'(misaligned), 32'd0);
        check("hrst_cnt", issue_count, 32'd0);

        // Reset while an instruction is being offered
        imem_ready = 1'b1; instr_ready = 1'b0;
        cyc();
        check("ir_valid_pre", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        cyc();
        check("ir_valid", 32'(instr_valid), 32'd0);
        check("ir_cnt", issue_count, 32'd0);
        check("ir_instr", instr, 32'd0);
        reset = 1'b0;
        #1;
        check("ir_fetch_req", 32'(imem_req), 32'd1);
        check("ir_fetch_addr", imem_addr, RST_PC);

        fetch_issue(32'h1000, 1'b0);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Owns the architectural program counter and the instruction-fetch handshake for the multicore CPU. It sits directly downstream of the PC jump-select stage: it supplies `pc_plus4` to that stage and loads the selected `next_pc` each time an instruction is handed to the cores. Between those two points it fetches from instruction memory through a request/ready handshake, holds the fetched word in a one-entry buffer, and supports stall and halt.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `next_pc` in 32: from the jump-select stage; sampled only on handoff.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32; combinational from `pc`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `imem_ready` in 1: memory returns `imem_rdata` in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: buffered instruction to the cores.
- `instr_valid` out 1: `instr` is offered to the cores.
- `instr_ready` in 1: cores accept `instr`.
- `stall` in 1: freezes fetch and issue while high.
- `halt` in 1: sampled on handoff; stops the fetch unit.
- `halted` out 1: unit is in HALTED.
- `misaligned` out 1: sticky flag; a handoff loaded a `next_pc` with nonzero bits [1:0].
- `issue_count` out 32: number of completed handoffs, wrapping.

## Operation
- States: FETCH, ISSUE, HALTED. State encoding is 2 bits.
- **FETCH**
  - `imem_req = ~stall & ~reset`.
  - On `imem_req & imem_ready`: `instr <= imem_rdata`, go to ISSUE.
  - `imem_ready` is ignored when `imem_req` is low.
- **ISSUE**
  - `instr_valid = ~stall`. `instr` holds stable.
  - Handoff is `instr_valid & instr_ready`. On handoff:
    - `pc <= {next_pc[31:2], 2'b00}`.
    - `issue_count <= issue_count + 1`.
    - If `next_pc[1:0] != 0`, set `misaligned`.
    - If `halt`, go to HALTED; otherwise go to FETCH.
  - `halt` and `next_pc` are ignored outside handoff.
- **HALTED**
  - `imem_req = 0`, `instr_valid = 0`, `halted = 1`.
  - `pc` and `issue_count` hold.
  - Only `reset` leaves HALTED.
- **Reset** (any state, including mid-handshake)
  - State goes to FETCH.
  - `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`.
  - `instr = 0`, `instr_valid = 0`, `halted = 0`, `misaligned = 0`, `issue_count = 0`.
  - `imem_req` is forced low while `reset` is high.
  - A fetch that was pending at reset is abandoned and is not re-issued at the old address.

## Timing
- Fastest fetch: `imem_req` and `imem_ready` both high in cycle N. Then `instr_valid` is high in N+1.
- Fastest handoff: handoff in N+1. Then the new `pc` is visible and `imem_req` is high in N+2.
- Peak throughput is one instruction per 2 cycles.
- `stall` takes effect in the same cycle. It masks `imem_req`/`instr_valid` combinationally and blocks all state updates for that cycle.
- `stall` and `imem_ready` high in the same cycle: no capture.
- `stall` and `instr_ready` high in the same cycle: no handoff.
- `pc` changes only on handoff or reset. It is stable for the whole FETCH/ISSUE window, so the jump-select stage sees a constant `pc_plus4`.
- `issue_count` wraps from 32'hFFFF_FFFF to 0 with no flag.
- `pc` wraps: `next_pc` = 32'hFFFF_FFFC yields `pc_plus4` = 0.

## Structure
- `pc_fetch_pkg` contains:
  - the state typedef (FETCH/ISSUE/HALTED);
  - `PC_WIDTH` = 32;
  - `PC_STEP` = 4.
- Single module. No sub-module: the PC register, the instruction buffer and the counter each need only a few lines.

## Test plan
- Release `reset`, hold `imem_ready` = 1 and `instr_ready` = 1, and drive `next_pc = pc_plus4`, with `RESET_PC` = 0x100. Required: `imem_addr` sequence 0x100, 0x104, 0x108, one fetch every 2 cycles, and `issue_count` = 3 after three handoffs.
- In ISSUE with `instr` = 0xDEADBEEF, hold `instr_ready` = 0 for 4 cycles, then drive `next_pc` = 0x40 with `instr_ready` = 1. Required: `instr` stays stable throughout, then `pc` = 0x40 and `pc_plus4` = 0x44.
- Assert `stall` in FETCH while `imem_ready` = 1. Required: `imem_req` = 0 and no capture. Release `stall`: required capture on the next `imem_ready`.
- Handoff with `halt` = 1. Required: `halted` = 1 and `imem_req` = 0 forever, with `pc` frozen. Pulse `reset`: required `pc` = `RESET_PC` and `halted` = 0.
- Handoff with `next_pc` = 0x0000_0036. Required: `pc` = 0x34, `misaligned` = 1, and `misaligned` stays set until reset.
- Assert `reset` while in ISSUE with `instr_valid` high. Required next cycle: `instr_valid` = 0, state FETCH, `issue_count` = 0.
